// File: rtl/expr_eval_unit_if.sv
// Term-stream handshake between the key/switch front end and expr_eval_unit.
interface expr_eval_unit_if #(
   parameter int OPND_W = 4
);
   logic              in_valid;
   logic              in_ready;
   logic [OPND_W-1:0] in_mag;
   logic              in_neg;
   logic [1:0]        in_op;
   logic              in_last;
   logic              eval_mode;

   modport master (output in_valid, in_mag, in_neg, in_op, in_last, eval_mode, input in_ready);
   modport slave  (input in_valid, in_mag, in_neg, in_op, in_last, eval_mode, output in_ready);
endinterface

// File: rtl/expr_eval_unit.sv
// Streaming signed expression evaluator (left-to-right or precedence) with BCD output.
// Optional macro SAT_ARITH_EN: saturate out-of-range intermediates instead of wrapping.
module expr_eval_unit #(
   parameter int DATA_W    = 8,
   parameter int OPND_W    = 4,
   parameter int MAX_TERMS = 5,
   parameter int DIGITS    = 3
) (
   input  logic                           CLOCK_50,
   input  logic                           RESET_N,
   input  logic                           clear,
   expr_eval_unit_if.slave                in_if,
   output logic signed [DATA_W-1:0]       result,
   output logic [4*DIGITS-1:0]            bcd,
   output logic                           neg,
   output logic                           zero,
   output logic                           div_by_zero,
   output logic                           overflow,
   output logic [$clog2(MAX_TERMS+1)-1:0] term_cnt,
   output logic                           busy,
   output logic                           done
);
   localparam int W     = DATA_W + OPND_W + 1;
   localparam int IDX_W = (MAX_TERMS > 1) ? $clog2(MAX_TERMS) : 1;
   localparam int CNT_W = $clog2(MAX_TERMS + 1);
   localparam int CV_W  = $clog2(DATA_W + 1);
   localparam int DD_W  = 4 * DIGITS + DATA_W;
   localparam logic signed [W-1:0] MAXV = W'(2 ** (DATA_W - 1) - 1);
   localparam logic signed [W-1:0] MINV = W'(-(2 ** (DATA_W - 1)));

   typedef enum logic [2:0] {IDLE, COLLECT, EVAL_MD, EVAL_AS, CONVERT, DONE} state_t;

   typedef struct packed {
      logic [DATA_W-1:0] val;
      logic              ovf;
      logic              dbz;
   } alu_t;

   function automatic logic [DATA_W-1:0] operand(input logic [OPND_W-1:0] m, input logic n);
      logic [DATA_W-1:0] e;
      e = {{(DATA_W - OPND_W){1'b0}}, m};
      return n ? -e : e;
   endfunction

   // Evaluate wide enough that no single op can lose information, then range-check.
   function automatic alu_t alu(input logic [DATA_W-1:0] a, input logic [1:0] op,
                                input logic [DATA_W-1:0] b);
      logic signed [W-1:0] wa, wb, w;
      alu_t r;
      r  = '0;
      wa = $signed({{(W - DATA_W){a[DATA_W-1]}}, a});
      wb = $signed({{(W - DATA_W){b[DATA_W-1]}}, b});
      case (op)
         2'b00:   w = wa + wb;
         2'b01:   w = wa - wb;
         2'b10:   w = wa * wb;
         default: begin
            if (b == '0) begin
               w     = '0;
               r.dbz = 1'b1;
            end else begin
               w = wa / wb;
            end
         end
      endcase
      r.ovf = (w > MAXV) || (w < MINV);
`ifdef SAT_ARITH_EN
      r.val = r.ovf ? (w[W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}})
                    : w[DATA_W-1:0];
`else
      r.val = w[DATA_W-1:0];
`endif
      return r;
   endfunction

   function automatic logic [DD_W-1:0] dd_step(input logic [DD_W-1:0] v);
      logic [DD_W-1:0] t;
      t = v;
      for (int i = 0; i < DIGITS; i++)
         if (t[DATA_W+4*i +: 4] >= 4'd5) t[DATA_W+4*i +: 4] = t[DATA_W+4*i +: 4] + 4'd3;
      return {t[DD_W-2:0], 1'b0};
   endfunction

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   result_q, result_d, prod_q, prod_d, acc_q, acc_d;
   logic [4*DIGITS-1:0] bcd_q, bcd_d;
   logic                neg_q, neg_d, zero_q, zero_d, dbz_q, dbz_d, ovf_q, ovf_d;
   logic                done_q, done_d, mode_q, mode_d, bnd_q, bnd_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d, md_idx_q, md_idx_d, red_cnt_q, red_cnt_d, as_idx_q, as_idx_d;
   logic [DD_W-1:0]     dd_q, dd_d;
   logic [CV_W-1:0]     cv_q, cv_d;
   logic [DATA_W-1:0]   term_q [MAX_TERMS];
   logic [DATA_W-1:0]   term_d [MAX_TERMS];
   logic [1:0]          op_q   [MAX_TERMS];
   logic [1:0]          op_d   [MAX_TERMS];
   logic [DATA_W-1:0]   red_q  [MAX_TERMS];
   logic [DATA_W-1:0]   red_d  [MAX_TERMS];
   logic                red_op_q [MAX_TERMS];
   logic                red_op_d [MAX_TERMS];

   logic              accept, md_last;
   logic [DATA_W-1:0] opnd, md_t;
   logic [1:0]        md_op;
   alu_t              fold_r, md_r, as_r;

   assign in_if.in_ready = (state_q == IDLE) || (state_q == COLLECT) || (state_q == DONE);
   assign accept  = in_if.in_valid & in_if.in_ready;
   assign opnd    = operand(in_if.in_mag, in_if.in_neg);
   assign fold_r  = alu(result_q, op_q[IDX_W'(cnt_q - 1'b1)], opnd);
   assign md_op   = op_q[IDX_W'(md_idx_q - 1'b1)];
   assign md_t    = term_q[IDX_W'(md_idx_q)];
   assign md_r    = alu(prod_q, md_op, md_t);
   assign md_last = (md_idx_q == cnt_q - 1'b1);
   assign as_r    = alu(acc_q, {1'b0, red_op_q[IDX_W'(as_idx_q)]}, red_q[IDX_W'(as_idx_q)]);

   always_comb begin
      state_d   = state_q;   result_d  = result_q;  prod_d    = prod_q;   acc_d  = acc_q;
      bcd_d     = bcd_q;     neg_d     = neg_q;     zero_d    = zero_q;   dbz_d  = dbz_q;
      ovf_d     = ovf_q;     done_d    = 1'b0;      mode_d    = mode_q;   bnd_d  = bnd_q;
      cnt_d     = cnt_q;     md_idx_d  = md_idx_q;  red_cnt_d = red_cnt_q;
      as_idx_d  = as_idx_q;  dd_d      = dd_q;      cv_d      = cv_q;
      term_d    = term_q;    op_d      = op_q;      red_d     = red_q;    red_op_d = red_op_q;

      case (state_q)
         IDLE, DONE: begin
            if (accept) begin
               dbz_d     = 1'b0;  ovf_d = 1'b0;  cnt_d = CNT_W'(1);
               mode_d    = in_if.eval_mode;
               term_d[0] = opnd;  op_d[0] = in_if.in_op;
               result_d  = opnd;  prod_d  = opnd;  bnd_d = 1'b0;
               md_idx_d  = CNT_W'(1);  red_cnt_d = '0;
               state_d   = !in_if.in_last ? COLLECT : (in_if.eval_mode ? EVAL_MD : CONVERT);
            end
         end
         COLLECT: begin
            if (accept) begin
               term_d[IDX_W'(cnt_q)] = opnd;
               op_d[IDX_W'(cnt_q)]   = in_if.in_op;
               cnt_d = cnt_q + 1'b1;
               if (!mode_q) begin
                  result_d = fold_r.val;
                  ovf_d    = ovf_q | fold_r.ovf;
                  dbz_d    = dbz_q | fold_r.dbz;
               end
               if (in_if.in_last || cnt_q == CNT_W'(MAX_TERMS - 1))
                  state_d = mode_q ? EVAL_MD : CONVERT;
            end
         end
         EVAL_MD: begin
            // prod_q holds the running */÷ chain; bnd_q is the +/- that precedes it.
            if (md_idx_q >= cnt_q) begin
               red_d[0] = prod_q;  red_op_d[0] = bnd_q;  red_cnt_d = CNT_W'(1);
            end else if (md_op[1]) begin
               ovf_d = ovf_q | md_r.ovf;
               dbz_d = dbz_q | md_r.dbz;
               if (md_last) begin
                  red_d[IDX_W'(red_cnt_q)]    = md_r.val;
                  red_op_d[IDX_W'(red_cnt_q)] = bnd_q;
                  red_cnt_d = red_cnt_q + 1'b1;
               end else begin
                  prod_d = md_r.val;
               end
            end else begin
               red_d[IDX_W'(red_cnt_q)]    = prod_q;
               red_op_d[IDX_W'(red_cnt_q)] = bnd_q;
               if (md_last) begin
                  red_d[IDX_W'(red_cnt_q + 1'b1)]    = md_t;
                  red_op_d[IDX_W'(red_cnt_q + 1'b1)] = md_op[0];
                  red_cnt_d = red_cnt_q + CNT_W'(2);
               end else begin
                  red_cnt_d = red_cnt_q + 1'b1;
                  prod_d    = md_t;
                  bnd_d     = md_op[0];
               end
            end
            md_idx_d = md_idx_q + 1'b1;
            if (md_idx_q >= cnt_q || md_last) begin
               state_d  = EVAL_AS;
               as_idx_d = '0;
               acc_d    = '0;
            end
         end
         EVAL_AS: begin
            acc_d    = as_r.val;
            ovf_d    = ovf_q | as_r.ovf;
            as_idx_d = as_idx_q + 1'b1;
            if (as_idx_q == red_cnt_q - 1'b1) begin
               result_d = as_r.val;
               state_d  = CONVERT;
            end
         end
         CONVERT: begin
            dd_d = dd_step(dd_q);
            cv_d = cv_q + 1'b1;
            if (cv_q == CV_W'(DATA_W - 1)) begin
               state_d = DONE;
               bcd_d   = dd_d[DD_W-1 -: 4*DIGITS];
               neg_d   = result_q[DATA_W-1];
               zero_d  = (result_q == '0);
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Load the converter from the value being committed, so CONVERT is exactly DATA_W cycles.
      if (state_d == CONVERT && state_q != CONVERT) begin
         dd_d = {{(4*DIGITS){1'b0}}, (result_d[DATA_W-1] ? -result_d : result_d)};
         cv_d = '0;
      end

      if (clear) begin
         state_d   = IDLE;  result_d = '0;  prod_d = '0;  acc_d = '0;  bcd_d = '0;
         neg_d     = 1'b0;  zero_d = 1'b1;  dbz_d = 1'b0;  ovf_d = 1'b0;  done_d = 1'b0;
         mode_d    = 1'b0;  bnd_d = 1'b0;  cnt_d = '0;  md_idx_d = '0;  red_cnt_d = '0;
         as_idx_d  = '0;  dd_d = '0;  cv_d = '0;
         for (int i = 0; i < MAX_TERMS; i++) begin
            term_d[i] = '0;  op_d[i] = '0;  red_d[i] = '0;  red_op_d[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q   <= IDLE;  result_q <= '0;  prod_q <= '0;  acc_q <= '0;  bcd_q <= '0;
         neg_q     <= 1'b0;  zero_q <= 1'b1;  dbz_q <= 1'b0;  ovf_q <= 1'b0;  done_q <= 1'b0;
         mode_q    <= 1'b0;  bnd_q <= 1'b0;  cnt_q <= '0;  md_idx_q <= '0;  red_cnt_q <= '0;
         as_idx_q  <= '0;  dd_q <= '0;  cv_q <= '0;
         for (int i = 0; i < MAX_TERMS; i++) begin
            term_q[i] <= '0;  op_q[i] <= '0;  red_q[i] <= '0;  red_op_q[i] <= 1'b0;
         end
      end else begin
         state_q   <= state_d;  result_q <= result_d;  prod_q <= prod_d;  acc_q <= acc_d;
         bcd_q     <= bcd_d;  neg_q <= neg_d;  zero_q <= zero_d;  dbz_q <= dbz_d;
         ovf_q     <= ovf_d;  done_q <= done_d;  mode_q <= mode_d;  bnd_q <= bnd_d;
         cnt_q     <= cnt_d;  md_idx_q <= md_idx_d;  red_cnt_q <= red_cnt_d;
         as_idx_q  <= as_idx_d;  dd_q <= dd_d;  cv_q <= cv_d;
         term_q    <= term_d;  op_q <= op_d;  red_q <= red_d;  red_op_q <= red_op_d;
      end
   end

   assign result      = result_q;
   assign bcd         = bcd_q;
   assign neg         = neg_q;
   assign zero        = zero_q;
   assign div_by_zero = dbz_q;
   assign overflow    = ovf_q;
   assign term_cnt    = cnt_q;
   assign busy        = (state_q == EVAL_MD) || (state_q == EVAL_AS) || (state_q == CONVERT);
   assign done        = done_q;
endmodule
